spawn_scheduler: RTL and testbench

//  Consumes the free-running pseudo-random words from the LFSR generators and turns them

---
 rtl/canasta_pkg.sv | 36 +++
 rtl/spawn_fifo.sv | 57 +++++
 rtl/spawn_scheduler.sv | 141 ++++++++++++++
 tb/tb_spawn_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canasta_pkg.sv
// Shared definitions for the Canasta spawn path: item type codes, the
// scheduler FSM states and the packed layout of one spawn request.
package canasta_pkg;

  localparam logic [1:0] ITEM_FRUIT = 2'd0;
  localparam logic [1:0] ITEM_BOMB  = 2'd1;
  localparam logic [1:0] ITEM_BONUS = 2'd2;

  localparam int X_W     = 10;
  localparam int TYPE_W  = 2;
  localparam int SPEED_W = 4;
  localparam int ENTRY_W = X_W + TYPE_W + SPEED_W;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_MAP    = 2'd2,
    ST_PUSH   = 2'd3
  } spawnState_t;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [TYPE_W-1:0]  itemType;
    logic [SPEED_W-1:0] speed;
  } spawnEntry_t;

  // Two of the eight 3-bit random codes are special items, the rest are fruit.
  function automatic logic [TYPE_W-1:0] classifyItem(input logic [2:0] r3);
    logic [TYPE_W-1:0] t;
    t = ITEM_FRUIT;
    if (r3 == 3'd6) t = ITEM_BOMB;
    else if (r3 == 3'd7) t = ITEM_BONUS;
    return t;
  endfunction

endpackage

// File: rtl/spawn_fifo.sv
// First-word-fall-through request buffer. The head entry is visible on
// o_data straight from storage; an empty FIFO presents all zeros.
import canasta_pkg::*;

module spawn_fifo #(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = o_empty ? '0 : r_mem[r_rdPtr];

  // Storage, wrapping pointers and occupancy count (0..DEPTH).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Turns the free-running LFSR words into timed spawn requests (x, type,
// speed) for falling items, buffered so the draw logic may stall.
import canasta_pkg::*;

module spawn_scheduler #(
  parameter int PERIOD     = 50,
  parameter int X_RANGE    = 448,
  parameter int X_OFFSET   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [8:0] rnd9,
  input  logic [2:0] rnd3,
  input  logic [4:0] rnd5,
  input  logic [1:0] level,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [9:0] spawn_x,
  output logic [1:0] spawn_type,
  output logic [3:0] spawn_speed,
  output logic [7:0] drop_count
);

  localparam int CNT_W = $clog2(PERIOD);

  spawnState_t          r_state;
  logic [CNT_W-1:0]     r_tickCnt;
  logic [8:0]           r_rnd9;
  logic [2:0]           r_rnd3;
  logic [1:0]           r_rnd5Low;
  logic [1:0]           r_level;
  spawnEntry_t          r_entry;
  logic [7:0]           r_dropCount;

  logic                 w_tickEn;
  logic                 w_terminal;
  logic [9:0]           w_r9Ext;
  logic [9:0]           w_foldedX;
  logic [SPEED_W-1:0]   w_speed;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifoFull;
  logic                 w_fifoEmpty;
  logic                 w_drop;
  logic [ENTRY_W-1:0]   w_headBits;
  spawnEntry_t          w_head;
  logic                 w_unusedRnd5;

  // Only the two low bits of the 5-bit LFSR word feed the speed.
  assign w_unusedRnd5 = ^rnd5[4:2];

  assign w_tickEn   = frame_tick && enable;
  assign w_terminal = w_tickEn && (r_tickCnt == CNT_W'(PERIOD - 1));

  // X_RANGE exceeds half the 9-bit span, so one conditional subtract folds it.
  assign w_r9Ext   = {1'b0, r_rnd9};
  assign w_foldedX = (w_r9Ext >= 10'(X_RANGE)) ? (w_r9Ext - 10'(X_RANGE)) : w_r9Ext;
  assign w_speed   = 4'd1 + {2'b00, r_rnd5Low} + {2'b00, r_level};

  assign w_push = (r_state == ST_PUSH);
  assign w_pop  = !w_fifoEmpty && spawn_ready;
  assign w_drop = w_push && w_fifoFull && !w_pop;

  // Frame-tick counter; frozen while disabled, wraps on the terminal tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tickCnt <= '0;
    end else if (w_tickEn) begin
      r_tickCnt <= w_terminal ? '0 : r_tickCnt + 1'b1;
    end
  end

  // Spawn sequencer: sample the random words, map them, then hand to the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_WAIT;
      r_rnd9    <= '0;
      r_rnd3    <= '0;
      r_rnd5Low <= '0;
      r_level   <= '0;
      r_entry   <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_terminal) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_rnd9    <= rnd9;
          r_rnd3    <= rnd3;
          r_rnd5Low <= rnd5[1:0];
          r_level   <= level;
          r_state   <= ST_MAP;
        end
        ST_MAP: begin
          r_entry.x        <= w_foldedX + 10'(X_OFFSET);
          r_entry.itemType <= classifyItem(r_rnd3);
          r_entry.speed    <= w_speed;
          r_state          <= ST_PUSH;
        end
        ST_PUSH: begin
          r_state <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  // Count spawns lost because the FIFO was full, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropCount <= '0;
    end else if (w_drop && (r_dropCount != 8'hFF)) begin
      r_dropCount <= r_dropCount + 1'b1;
    end
  end

  spawn_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_entry),
    .o_data  (w_headBits),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  assign w_head      = spawnEntry_t'(w_headBits);
  assign spawn_valid = !w_fifoEmpty;
  assign spawn_x     = w_head.x;
  assign spawn_type  = w_head.itemType;
  assign spawn_speed = w_head.speed;
  assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: a fixed vector table, hand-written multi-cycle
// sequences, and a randomized run checked every cycle against a queue model.
module tb_spawn_scheduler;

  localparam int PERIOD     = 4;
  localparam int X_RANGE    = 448;
  localparam int X_OFFSET   = 16;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       frame_tick;
  logic [8:0] rnd9;
  logic [2:0] rnd3;
  logic [4:0] rnd5;
  logic [1:0] level;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;
  logic [1:0] spawn_type;
  logic [3:0] spawn_speed;
  logic [7:0] drop_count;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  spawn_scheduler #(
    .PERIOD     (PERIOD),
    .X_RANGE    (X_RANGE),
    .X_OFFSET   (X_OFFSET),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .rnd9        (rnd9),
    .rnd3        (rnd3),
    .rnd5        (rnd5),
    .level       (level),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_x     (spawn_x),
    .spawn_type  (spawn_type),
    .spawn_speed (spawn_speed),
    .drop_count  (drop_count)
  );

  // Reference model: a queue of requests, a tick count, and a countdown of
  // clock edges from a terminal tick until its request reaches the buffer.
  typedef struct {
    int x;
    int itemType;
    int speed;
  } entry_t;

  entry_t modelQ[$];
  entry_t modelPending;
  int     modelCnt       = 0;
  int     modelCountdown = 0;
  int     modelDrop      = 0;

  function automatic entry_t mapSpawn(int r9, int r3, int r5, int lvl);
    entry_t e;
    e.x        = (r9 % X_RANGE) + X_OFFSET;
    e.itemType = (r3 == 6) ? 1 : ((r3 == 7) ? 2 : 0);
    e.speed    = 1 + (r5 % 4) + lvl;
    return e;
  endfunction

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin : refModel
    bit popNow;
    bit pushNow;
    bit busy;
    if (reset) begin
      modelQ.delete();
      modelCnt       = 0;
      modelCountdown = 0;
      modelDrop      = 0;
    end else begin
      popNow  = (modelQ.size() > 0) && spawn_ready;
      pushNow = 1'b0;
      busy    = (modelCountdown != 0);
      if (modelCountdown == 3)
        modelPending = mapSpawn(int'(rnd9), int'(rnd3), int'(rnd5), int'(level));
      if (modelCountdown == 1) pushNow = 1'b1;
      if (modelCountdown > 0) modelCountdown--;
      if (popNow) void'(modelQ.pop_front());
      if (pushNow) begin
        if (modelQ.size() < FIFO_DEPTH) modelQ.push_back(modelPending);
        else if (modelDrop < 255) modelDrop++;
      end
      if (frame_tick && enable) begin
        if (modelCnt == PERIOD - 1) begin
          modelCnt = 0;
          if (!busy) modelCountdown = 3;
        end else begin
          modelCnt++;
        end
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] required);
    assertCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // Compare every output against the reference model.
  task automatic checkOutput(input string tag);
    entry_t head;
    head = '{0, 0, 0};
    if (modelQ.size() > 0) head = modelQ[0];
    checkVal({tag, ".valid"}, spawn_valid, (modelQ.size() > 0) ? 1 : 0);
    checkVal({tag, ".x"},     spawn_x,     head.x);
    checkVal({tag, ".type"},  spawn_type,  head.itemType);
    checkVal({tag, ".speed"}, spawn_speed, head.speed);
    checkVal({tag, ".drop"},  drop_count,  modelDrop);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkOutput("model");
  endtask

  task automatic applyStimulus(input logic [8:0] r9, input logic [2:0] r3,
                               input logic [4:0] r5, input logic [1:0] lvl);
    rnd9  = r9;
    rnd3  = r3;
    rnd5  = r5;
    level = lvl;
  endtask

  // Issue n frame ticks four cycles apart; optionally idle after the last.
  task automatic doTicks(input int n, input bit trailing);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if ((i < n - 1) || trailing) repeat (3) step();
    end
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
    reset      = 1'b0;
  endtask

  // Count cycles until spawn_valid rises, bounded.
  task automatic waitValid(output int waited);
    waited = 0;
    while (!spawn_valid && waited < 12) begin
      step();
      waited++;
    end
  endtask

  typedef struct {
    logic [8:0] r9;
    logic [2:0] r3;
    logic [4:0] r5;
    logic [1:0] lvl;
    int         expX;
    int         expType;
    int         expSpeed;
  } vector_t;

  vector_t vectors[6];

  initial begin
    int waited;
    int gap;
    int expX[4];
    int expType[4];
    int expSpeed[4];

    vectors[0] = '{9'd470, 3'd6, 5'b00011, 2'd2, 38,  1, 6};
    vectors[1] = '{9'd100, 3'd7, 5'd0,     2'd0, 116, 2, 1};
    vectors[2] = '{9'd447, 3'd0, 5'd0,     2'd0, 463, 0, 1};
    vectors[3] = '{9'd448, 3'd5, 5'd31,    2'd3, 16,  0, 7};
    vectors[4] = '{9'd0,   3'd6, 5'd2,     2'd1, 16,  1, 4};
    vectors[5] = '{9'd511, 3'd7, 5'd1,     2'd3, 79,  2, 5};

    reset       = 1'b1;
    enable      = 1'b1;
    frame_tick  = 1'b0;
    spawn_ready = 1'b0;
    applyStimulus(9'd0, 3'd0, 5'd0, 2'd0);

    // Reset held with ticks present.
    doReset(3);
    checkVal("rstValid", spawn_valid, 0);
    checkVal("rstX",     spawn_x,     0);
    checkVal("rstType",  spawn_type,  0);
    checkVal("rstSpeed", spawn_speed, 0);
    checkVal("rstDrop",  drop_count,  0);

    // Table of single spawns: latency, mapping, and pop on the next edge.
    for (int v = 0; v < 6; v++) begin
      doReset(1);
      spawn_ready = 1'b1;
      applyStimulus(vectors[v].r9, vectors[v].r3, vectors[v].r5, vectors[v].lvl);
      doTicks(PERIOD, 1'b0);
      waitValid(waited);
      checkVal($sformatf("vec%0d.latency", v), waited, 3);
      checkVal($sformatf("vec%0d.x", v),     spawn_x,     vectors[v].expX);
      checkVal($sformatf("vec%0d.type", v),  spawn_type,  vectors[v].expType);
      checkVal($sformatf("vec%0d.speed", v), spawn_speed, vectors[v].expSpeed);
      step();
      checkVal($sformatf("vec%0d.popped", v), spawn_valid, 0);
    end

    // Stalled consumer: six spawns, four held, two dropped.
    doReset(1);
    spawn_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(9'(20 * k + 5), 3'(k), 5'(k), 2'(k % 4));
      doTicks(PERIOD, 1'b1);
    end
    repeat (4) step();
    checkVal("fullValid", spawn_valid, 1);
    checkVal("fullDrop",  drop_count,  2);
    checkVal("fullHeadX", spawn_x,     21);

    // Full FIFO with a pop exactly in the push cycle: accepted, no drop.
    applyStimulus(9'd300, 3'd6, 5'd1, 2'd1);
    doTicks(PERIOD, 1'b0);
    step();
    step();
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    repeat (2) step();
    checkVal("pushPopDrop",  drop_count, 2);
    checkVal("pushPopHeadX", spawn_x,    41);

    expX     = '{41, 61, 81, 316};
    expType  = '{0, 0, 0, 1};
    expSpeed = '{3, 5, 7, 3};
    spawn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("drain%0d.valid", i), spawn_valid, 1);
      checkVal($sformatf("drain%0d.x", i),     spawn_x,     expX[i]);
      checkVal($sformatf("drain%0d.type", i),  spawn_type,  expType[i]);
      checkVal($sformatf("drain%0d.speed", i), spawn_speed, expSpeed[i]);
      step();
    end
    checkVal("drainEmpty", spawn_valid, 0);

    // Disabled ticks are ignored; two more enabled ticks complete the period.
    doReset(1);
    spawn_ready = 1'b1;
    applyStimulus(9'd100, 3'd7, 5'd0, 2'd0);
    doTicks(2, 1'b1);
    enable = 1'b0;
    doTicks(10, 1'b1);
    enable = 1'b1;
    doTicks(1, 1'b1);
    checkVal("enableNoSpawn", spawn_valid, 0);
    doTicks(1, 1'b0);
    waitValid(waited);
    checkVal("enableLatency", waited, 3);
    checkVal("enableX", spawn_x, 116);
    step();

    // Reset during MAP discards the request and clears the tick count.
    doTicks(PERIOD, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkVal("mapRstValid", spawn_valid, 0);
    repeat (5) step();
    checkVal("mapRstLater", spawn_valid, 0);
    doTicks(PERIOD - 1, 1'b1);
    checkVal("mapRstCnt", spawn_valid, 0);
    doTicks(1, 1'b0);
    waitValid(waited);
    checkVal("mapRstRespawn", waited, 3);
    step();

    // Randomized traffic against the model.
    doReset(2);
    gap = 0;
    for (int c = 0; c < 1500; c++) begin
      rnd9        = 9'($urandom);
      rnd3        = 3'($urandom);
      rnd5        = 5'($urandom);
      level       = 2'($urandom);
      enable      = ($urandom_range(0, 9) != 0);
      spawn_ready = (c < 700) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      if (gap == 0) begin
        frame_tick = 1'b1;
        gap        = $urandom_range(3, 6);
      end else begin
        frame_tick = 1'b0;
        gap--;
      end
      step();
    end
    reset      = 1'b0;
    frame_tick = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
